// File: rtl/ahb_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// ahb_to_apb_bridge
//
// AHB-Lite slave to APB3 master bridge. Each accepted AHB transfer (single
// NONSEQ/SEQ beat) is replayed as one APB setup/access sequence. The AHB data
// phase is stalled with HREADYOUT=0 until the APB slave answers with PREADY.
// An APB slave error is returned as the two-cycle AHB ERROR response.
//
// Ports
//   HCLK, HRESET        clock, asynchronous active-high reset
//   HSEL, HADDR,        AHB address phase: select, address, transfer type,
//   HTRANS, HWRITE,     direction and bus-wide ready
//   HREADY
//   HWDATA              AHB write data (data phase)
//   HREADYOUT, HRESP,   AHB slave response: ready, OKAY/ERROR, read data
//   HRDATA
//   PSEL, PENABLE,      APB master control, word-aligned address, write data
//   PWRITE, PADDR,
//   PWDATA
//   PRDATA, PREADY,     APB slave response
//   PSLVERR
// -----------------------------------------------------------------------------
module ahb_to_apb_bridge #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [31:0]           HRDATA,
   output logic                  HRESP,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]           PWDATA,
   input  logic [31:0]           PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    ready_state;
   logic                    accept;
   logic                    rd_capture;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic                    pwrite_q;
   logic [31:0]             hrdata_q;

   // Byte-lane bits and the SEQ/NONSEQ distinction carry no meaning for a
   // word-wide APB single transfer.
   logic                    unused_inputs;
   assign unused_inputs = ^{HADDR[1:0], HTRANS[0]};

   // A new address phase can only be taken while this slave is signalling
   // ready; decoding from the state register avoids a loop through HREADYOUT.
   assign ready_state = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
   assign accept      = HSEL & HREADY & HTRANS[1] & ready_state;

   // Read data is captured only on a successful completion of a read.
   assign rd_capture  = (state == S_ACCESS) & PREADY & ~PSLVERR & ~pwrite_q;

   // NOTE: every output of this block gets a default before the case so that
   // no path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      PSEL       = 1'b0;
      PENABLE    = 1'b0;
      HREADYOUT  = 1'b1;
      HRESP      = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            state_next = accept ? S_SETUP : S_IDLE;
         end
         S_ERR2: begin
            HRESP      = 1'b1;
            state_next = accept ? S_SETUP : S_IDLE;
         end
         S_SETUP: begin
            PSEL       = 1'b1;
            HREADYOUT  = 1'b0;
            state_next = S_ACCESS;
         end
         S_ACCESS: begin
            PSEL      = 1'b1;
            PENABLE   = 1'b1;
            HREADYOUT = 1'b0;
            if (PREADY) begin
               state_next = PSLVERR ? S_ERR1 : S_DONE;
            end
         end
         S_ERR1: begin
            HREADYOUT  = 1'b0;
            HRESP      = 1'b1;
            state_next = S_ERR2;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= S_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         hrdata_q <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            paddr_q  <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
            pwrite_q <= HWRITE;
         end
         if (rd_capture) begin
            hrdata_q <= PRDATA;
         end
      end
   end

   assign PADDR  = paddr_q;
   assign PWRITE = pwrite_q;
   assign HRDATA = hrdata_q;

   // AHB holds HWDATA while the data phase is stalled, so a direct pass-through
   // is stable for the whole APB transfer; it is zeroed when APB is idle.
   assign PWDATA = PSEL ? HWDATA : 32'h0;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_ahb_to_apb_bridge
//
// Self-checking bench for ahb_to_apb_bridge. The driver plans each AHB
// transfer at transaction level (address, direction, wait states, error) and
// expands it into the bus-visible cycle sequence it must produce; a single
// compare process checks every cycle against that expectation. Directed
// transfers add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_ahb_to_apb_bridge;

   logic        HCLK;
   logic        HRESET;
   logic        HSEL;
   logic [15:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   ahb_to_apb_bridge #(.ADDR_WIDTH(16)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRDATA    (HRDATA),
      .HRESP     (HRESP),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // Expected bus-visible values for one clock cycle.
   typedef struct packed {
      logic        psel;
      logic        penable;
      logic        hreadyout;
      logic        hresp;
      logic        pwrite;
      logic [15:0] paddr;
      logic [31:0] pwdata;
      logic [31:0] hrdata;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   int          n_checks  = 0;
   int          n_errors  = 0;
   int          stall_run = 0;
   int          last_stall = 0;

   // Transaction-level model state: last accepted address/direction and the
   // last successfully read word.
   logic [15:0] m_paddr  = '0;
   logic        m_pwrite = 1'b0;
   logic [31:0] m_hrdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic psel, input logic pen, input logic hrdy,
                       input logic hresp, input logic [31:0] pwdata);
      exp_t e;
      e.psel      = psel;
      e.penable   = pen;
      e.hreadyout = hrdy;
      e.hresp     = hresp;
      e.pwrite    = m_pwrite;
      e.paddr     = m_paddr;
      e.pwdata    = pwdata;
      e.hrdata    = m_hrdata;
      exp_q.push_back(e);
   endtask

   // Compare process: one expectation per cycle, checked mid-cycle.
   always @(negedge HCLK) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check("psel",      32'(PSEL),      32'(cur.psel));
         check("penable",   32'(PENABLE),   32'(cur.penable));
         check("hreadyout", 32'(HREADYOUT), 32'(cur.hreadyout));
         check("hresp",     32'(HRESP),     32'(cur.hresp));
         check("pwrite",    32'(PWRITE),    32'(cur.pwrite));
         check("paddr",     32'(PADDR),     32'(cur.paddr));
         check("pwdata",    PWDATA,         cur.pwdata);
         check("hrdata",    HRDATA,         cur.hrdata);
         if (!HREADYOUT) begin
            stall_run++;
         end else if (stall_run != 0) begin
            last_stall = stall_run;
            stall_run  = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   // Random inputs that can never form an accepted address phase.
   task automatic idle_inputs();
      HSEL    = 1'($urandom);
      HREADY  = 1'($urandom);
      HTRANS  = 2'($urandom);
      case ($urandom_range(0, 2))
         0:       HSEL      = 1'b0;
         1:       HREADY    = 1'b0;
         default: HTRANS[1] = 1'b0;
      endcase
      HADDR   = 16'($urandom);
      HWRITE  = 1'($urandom);
      HWDATA  = $urandom;
      PRDATA  = $urandom;
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
   endtask

   task automatic idle_cycle();
      next_cycle();
      idle_inputs();
      push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
   endtask

   // Issues the address phase in the current (ready) cycle and returns in the
   // final response cycle (DONE or ERR2), where a next transfer may start.
   task automatic xfer(input logic [15:0] addr, input logic write, input logic [31:0] wdata,
                       input int waits, input logic err, input logic [31:0] rdata);
      HSEL   = 1'b1;
      HREADY = 1'b1;
      HTRANS = {1'b1, 1'($urandom)};
      HADDR  = addr;
      HWRITE = write;
      // Setup cycle: address-phase signals are don't-care noise from here on.
      next_cycle();
      HSEL    = 1'($urandom);
      HREADY  = 1'($urandom);
      HTRANS  = 2'($urandom);
      HADDR   = 16'($urandom);
      HWRITE  = 1'($urandom);
      HWDATA  = wdata;
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
      m_paddr  = addr & 16'hFFFC;
      m_pwrite = write;
      push(1'b1, 1'b0, 1'b0, 1'b0, wdata);
      for (int i = 0; i <= waits; i++) begin
         next_cycle();
         PREADY  = (i == waits);
         PSLVERR = (i == waits) ? err : 1'($urandom);
         PRDATA  = (i == waits) ? rdata : $urandom;
         push(1'b1, 1'b1, 1'b0, 1'b0, wdata);
      end
      next_cycle();
      idle_inputs();
      if (!err) begin
         if (!write) m_hrdata = rdata;
         push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      end else begin
         push(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
         next_cycle();
         idle_inputs();
         push(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      end
   endtask

   initial begin
      HRESET = 1'b1;
      idle_inputs();
      repeat (2) @(posedge HCLK);
      #1;
      check("rst_psel",      32'(PSEL),      32'h0);
      check("rst_penable",   32'(PENABLE),   32'h0);
      check("rst_pwrite",    32'(PWRITE),    32'h0);
      check("rst_paddr",     32'(PADDR),     32'h0);
      check("rst_hrdata",    HRDATA,         32'h0);
      check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
      check("rst_hresp",     32'(HRESP),     32'h0);
      HRESET = 1'b0;
      push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

      // Write, zero wait states.
      xfer(16'h2004, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0);
      check("wr_done_hresp", 32'(HRESP),  32'h0);
      check("wr_paddr",      32'(PADDR),  32'h2004);
      check("wr_pwrite",     32'(PWRITE), 32'h1);
      idle_cycle();
      check("wr_stall", 32'(last_stall), 32'd2);

      // Read, two wait states.
      xfer(16'h1008, 1'b0, $urandom, 2, 1'b0, 32'h12345678);
      check("rd_hrdata", HRDATA, 32'h12345678);
      idle_cycle();
      check("rd_stall", 32'(last_stall), 32'd4);

      // Slave error on a write.
      xfer(16'h5000, 1'b1, 32'h0000_5A5A, 0, 1'b1, 32'hFFFF_FFFF);
      check("err2_hreadyout", 32'(HREADYOUT), 32'h1);
      check("err2_hresp",     32'(HRESP),     32'h1);
      idle_cycle();
      check("err_idle_hresp", 32'(HRESP),      32'h0);
      check("err_stall",      32'(last_stall), 32'd3);
      check("err_hrdata",     HRDATA,          32'h12345678);

      // Back-to-back: read then write accepted in DONE.
      xfer(16'h0000, 1'b0, $urandom, 0, 1'b0, 32'hA5A5_0001);
      xfer(16'h4000, 1'b1, 32'h0BAD_F00D, 0, 1'b0, 32'h0);
      check("b2b_paddr",  32'(PADDR),  32'h4000);
      check("b2b_pwrite", 32'(PWRITE), 32'h1);
      check("b2b_hrdata", HRDATA,      32'hA5A5_0001);
      idle_cycle();
      check("b2b_stall", 32'(last_stall), 32'd2);

      // Ignored transfers: IDLE type with HSEL=1, then NONSEQ with HREADY=0.
      next_cycle();
      idle_inputs();
      HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b00;
      push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      next_cycle();
      HSEL = 1'b1; HREADY = 1'b0; HTRANS = 2'b10;
      push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      idle_cycle();
      check("ign_psel",  32'(PSEL),  32'h0);
      check("ign_paddr", 32'(PADDR), 32'h4000);

      // Reset during ACCESS.
      HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HADDR = 16'h3000; HWRITE = 1'b0;
      next_cycle();
      idle_inputs();
      HWDATA = 32'h0;
      m_paddr  = 16'h3000;
      m_pwrite = 1'b0;
      push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      next_cycle();
      PREADY = 1'b0;
      check("pre_rst_penable", 32'(PENABLE), 32'h1);
      HRESET = 1'b1;
      #1;
      check("rst_mid_psel",      32'(PSEL),      32'h0);
      check("rst_mid_penable",   32'(PENABLE),   32'h0);
      check("rst_mid_hreadyout", 32'(HREADYOUT), 32'h1);
      m_paddr  = '0;
      m_pwrite = 1'b0;
      m_hrdata = '0;
      push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      idle_cycle();
      HRESET = 1'b0;
      xfer(16'h1000, 1'b0, $urandom, 1, 1'b0, 32'hCAFE_0123);
      check("post_rst_hrdata", HRDATA, 32'hCAFE_0123);
      check("post_rst_paddr",  32'(PADDR), 32'h1000);

      // Randomized traffic: gaps, wait states, errors, misaligned addresses.
      for (int n = 0; n < 200; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_cycle();
         xfer(16'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0), $urandom);
      end

      idle_cycle();
      idle_cycle();
      @(negedge HCLK);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
